// File: rtl/inst_issue_queue_pkg.sv
// Shared issue-queue defines (instruction buses, correction pack width, issue modes)
// plus the push/pop arbitration helpers used by the queue control.
`ifndef INST_ISSUE_QUEUE_DEFINES
`define INST_ISSUE_QUEUE_DEFINES
`define InstBus           31:0
`define InstAddrBus       31:0
`define SIZE_OF_CORR_PACK 88
`define DualIssue         1'b1
`define SingleIssue       1'b0
`endif

package inst_issue_queue_pkg;

    localparam int unsigned InstW = 32;
    localparam int unsigned AddrW = 32;

    // Fetch offers 0..2; the encoding 3 is clamped to 2. Nothing is taken while full.
    function automatic logic [1:0] calc_push_n(input logic full, input logic [1:0] push_num);
        if (full) begin
            return 2'd0;
        end
        return (push_num == 2'd3) ? 2'd2 : push_num;
    endfunction

    // Dual issue with a single valid entry degrades to a single pop.
    function automatic logic [1:0] calc_pop_n(input logic issued, input logic mode,
                                              input logic has1, input logic has2);
        if (!issued || !has1) begin
            return 2'd0;
        end
        if (mode == `DualIssue && has2) begin
            return 2'd2;
        end
        return 2'd1;
    endfunction

endpackage

// File: rtl/inst_issue_queue_ram.sv
// Issue-queue storage: two write ports (tail, tail+1) and two asynchronous read
// ports (head, head+1). Contents are intentionally not reset.
module issue_queue_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4,
    parameter int unsigned WIDTH = 152
) (
    input  logic             clk,
    input  logic             we1_i,
    input  logic [PTR_W-1:0] waddr1_i,
    input  logic [WIDTH-1:0] wdata1_i,
    input  logic             we2_i,
    input  logic [PTR_W-1:0] waddr2_i,
    input  logic [WIDTH-1:0] wdata2_i,
    input  logic [PTR_W-1:0] raddr1_i,
    input  logic [PTR_W-1:0] raddr2_i,
    output logic [WIDTH-1:0] rdata1_o,
    output logic [WIDTH-1:0] rdata2_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The two write addresses are always distinct (tail and tail+1).
    always_ff @(posedge clk) begin
        if (we1_i) begin
            mem[waddr1_i] <= wdata1_i;
        end
        if (we2_i) begin
            mem[waddr2_i] <= wdata2_i;
        end
    end

    assign rdata1_o = mem[raddr1_i];
    assign rdata2_o = mem[raddr2_i];

endmodule

// File: rtl/inst_issue_queue.sv
// Circular instruction buffer between fetch and dual-issue decode: accepts 0-2
// instructions per cycle and retires 0-2 from the head on decode's verdict.
module inst_issue_queue
    import inst_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PTR_W  = $clog2(DEPTH),
    parameter int unsigned CORR_W = `SIZE_OF_CORR_PACK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic [1:0]          push_num_i,
    input  logic [`InstBus]     push_inst1_i,
    input  logic [`InstBus]     push_inst2_i,
    input  logic [`InstAddrBus] push_addr1_i,
    input  logic [`InstAddrBus] push_addr2_i,
    input  logic [CORR_W-1:0]   push_corr1_i,
    input  logic [CORR_W-1:0]   push_corr2_i,
    input  logic                issued_i,
    input  logic                issue_mode_i,
    output logic [`InstBus]     inst1_o,
    output logic [`InstBus]     inst2_o,
    output logic [`InstAddrBus] inst1_addr_o,
    output logic [`InstAddrBus] inst2_addr_o,
    output logic [CORR_W-1:0]   inst1_corr_o,
    output logic [CORR_W-1:0]   inst2_corr_o,
    output logic                issue_en_o,
    output logic                inst2_valid_o,
    output logic                full_o,
    output logic [PTR_W:0]      count_o
);

    localparam int unsigned EntW = InstW + AddrW + CORR_W;
    localparam logic [PTR_W:0] FullThresh = (PTR_W + 1)'(DEPTH - 2);

    logic [PTR_W-1:0] head_q, tail_q, head_p1, tail_p1;
    logic [PTR_W:0]   count_q;
    logic [1:0]       push_n, pop_n;
    logic             has1, has2;
    logic [EntW-1:0]  rdata1, rdata2;

    // Pointers are exactly PTR_W bits, so +1 wraps modulo DEPTH for free.
    assign head_p1 = head_q + 1'b1;
    assign tail_p1 = tail_q + 1'b1;

    assign has1   = (count_q != '0);
    assign has2   = (count_q > (PTR_W + 1)'(1));
    assign full_o = (count_q > FullThresh);
    assign push_n = calc_push_n(full_o, push_num_i);
    assign pop_n  = calc_pop_n(issued_i, issue_mode_i, has1, has2);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(pop_n);
            tail_q  <= tail_q + PTR_W'(push_n);
            count_q <= count_q + (PTR_W + 1)'(push_n) - (PTR_W + 1)'(pop_n);
        end
    end

    issue_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (EntW)
    ) u_ram (
        .clk      (clk),
        .we1_i    (!rst && !flush_i && (push_n != 2'd0)),
        .waddr1_i (tail_q),
        .wdata1_i ({push_corr1_i, push_addr1_i, push_inst1_i}),
        .we2_i    (!rst && !flush_i && (push_n == 2'd2)),
        .waddr2_i (tail_p1),
        .wdata2_i ({push_corr2_i, push_addr2_i, push_inst2_i}),
        .raddr1_i (head_q),
        .raddr2_i (head_p1),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    assign {inst1_corr_o, inst1_addr_o, inst1_o} = has1 ? rdata1 : '0;
    assign {inst2_corr_o, inst2_addr_o, inst2_o} = has2 ? rdata2 : '0;

    assign issue_en_o    = has1;
    assign inst2_valid_o = has2;
    assign count_o       = count_q;

endmodule
